// File: rtl/spi_regbank_sync.sv
// SPI mode-0 slave register bank, fully oversampled into the clk domain.
// Frames are {mode, idx[6:0], clr, set}; commits happen on the CS rising edge.
module spi_regbank_sync #(
    parameter int               N_REGS       = 8,
    parameter int               REG_W        = 4,
    parameter logic [REG_W-1:0] RESET_VAL    = '0,
    parameter int               SOFT_RST_IDX = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      spi_clk,
    input  logic                      spi_cs,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    output logic [N_REGS*REG_W-1:0]   regs_out,
    output logic                      commit_stb,
    output logic [6:0]                commit_idx,
    output logic [7:0]                err_count
);

    localparam int               FRAME_W   = 8 + 2 * REG_W;
    localparam int               CNT_W     = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_ADDR  = CNT_W'(7);
    localparam logic [6:0]       SOFT_IDX  = 7'(SOFT_RST_IDX);

    // Synchronisers plus one edge-detect stage per SPI pin
    logic [1:0] sclk_sync_reg;
    logic [1:0] cs_sync_reg;
    logic [1:0] mosi_sync_reg;
    logic       sclk_d_reg;
    logic       cs_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            cs_sync_reg   <= '0;
            mosi_sync_reg <= '0;
            sclk_d_reg    <= 1'b0;
            cs_d_reg      <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[0], spi_clk};
            cs_sync_reg   <= {cs_sync_reg[0], spi_cs};
            mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
            sclk_d_reg    <= sclk_sync_reg[1];
            cs_d_reg      <= cs_sync_reg[1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_rise;
    logic cs_fall;

    assign sclk_s    = sclk_sync_reg[1];
    assign cs_s      = cs_sync_reg[1];
    assign mosi_s    = mosi_sync_reg[1];
    assign sclk_rise = sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s & sclk_d_reg;
    assign cs_rise   = cs_s & ~cs_d_reg;
    assign cs_fall   = ~cs_s & cs_d_reg;

    logic                 armed_reg;
    logic                 in_frame_reg;
    logic [CNT_W-1:0]     bit_cnt_reg;
    logic [FRAME_W-1:0]   rx_reg;
    logic [REG_W-1:0]     tx_reg;
    logic                 tx_en_reg;
    logic                 miso_reg;
    logic [REG_W-1:0]     snap_val;
    logic [6:0]           addr_idx;

    // Index is complete on the SCLK edge that samples the last address bit
    assign addr_idx = {rx_reg[5:0], mosi_s};

    always_comb begin
        snap_val = '0;
        if (addr_idx != SOFT_IDX) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (addr_idx == 7'(i)) begin
                    snap_val = regs_out[i*REG_W +: REG_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg    <= 1'b0;
            in_frame_reg <= 1'b0;
            bit_cnt_reg  <= '0;
            rx_reg       <= '0;
            tx_reg       <= '0;
            tx_en_reg    <= 1'b0;
            miso_reg     <= 1'b0;
        end else begin
            if (cs_s) begin
                armed_reg <= 1'b1;
            end
            if (cs_fall) begin
                in_frame_reg <= armed_reg;
                bit_cnt_reg  <= '0;
                rx_reg       <= '0;
                tx_reg       <= '0;
                tx_en_reg    <= 1'b0;
                miso_reg     <= 1'b0;
            end else if (cs_rise) begin
                // CS edge wins over any coincident SCLK edge
                in_frame_reg <= 1'b0;
                tx_en_reg    <= 1'b0;
                miso_reg     <= 1'b0;
            end else if (cs_s) begin
                tx_en_reg <= 1'b0;
                miso_reg  <= 1'b0;
            end else if (in_frame_reg) begin
                if (sclk_rise) begin
                    rx_reg <= {rx_reg[FRAME_W-2:0], mosi_s};
                    if (bit_cnt_reg != CNT_MAX) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                    if (bit_cnt_reg == CNT_ADDR) begin
                        tx_reg    <= snap_val;
                        tx_en_reg <= 1'b1;
                    end
                end else if (sclk_fall && tx_en_reg) begin
                    miso_reg <= tx_reg[REG_W-1];
                    tx_reg   <= tx_reg << 1;
                end
            end
        end
    end

    assign spi_miso = miso_reg & ~spi_cs;

    logic               frame_done;
    logic               frame_ok;
    logic               frame_bad;
    logic               frame_mode;
    logic [6:0]         frame_idx;
    logic [REG_W-1:0]   frame_clr;
    logic [REG_W-1:0]   frame_set;
    logic               soft_hit;

    assign frame_done = cs_rise & in_frame_reg;
    assign frame_ok   = frame_done & (bit_cnt_reg == CNT_FRAME);
    assign frame_bad  = frame_done & (bit_cnt_reg != CNT_FRAME);
    assign frame_mode = rx_reg[FRAME_W-1];
    assign frame_idx  = rx_reg[FRAME_W-2 -: 7];
    assign frame_clr  = rx_reg[2*REG_W-1 -: REG_W];
    assign frame_set  = rx_reg[REG_W-1:0];
    assign soft_hit   = (frame_idx == SOFT_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_stb <= 1'b0;
            commit_idx <= '0;
            err_count  <= '0;
        end else begin
            commit_stb <= frame_ok;
            if (frame_ok) begin
                commit_idx <= frame_idx;
            end
            if (frame_bad && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

    // Per-bit: set only -> 1, clr only -> 0, both -> toggle, neither -> hold
    function automatic logic [REG_W-1:0] stc_update(
        input logic [REG_W-1:0] cur,
        input logic [REG_W-1:0] set_v,
        input logic [REG_W-1:0] clr_v
    );
        return (cur & ~(set_v | clr_v)) | (set_v & ~clr_v) | (~cur & set_v & clr_v);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : g_reg
            logic [REG_W-1:0] val_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    val_reg <= RESET_VAL;
                end else if (frame_ok) begin
                    if (soft_hit) begin
                        val_reg <= RESET_VAL;
                    end else if (frame_idx == 7'(gi)) begin
                        val_reg <= frame_mode ? frame_set
                                              : stc_update(val_reg, frame_set, frame_clr);
                    end
                end
            end

            assign regs_out[gi*REG_W +: REG_W] = val_reg;
        end
    endgenerate

endmodule

// File: tb/tb_spi_regbank_sync.sv
// Directed bench for spi_regbank_sync: default 8x4 instance plus a 16x8 instance
// sharing the same SPI pins (frames of the wrong length are just errors for the other).
module tb_spi_regbank_sync;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         spi_clk = 1'b0;
    logic         spi_cs = 1'b1;
    logic         spi_mosi = 1'b0;

    logic         miso_a;
    logic [31:0]  regs_a;
    logic         stb_a;
    logic [6:0]   idx_a;
    logic [7:0]   err_a;

    logic         miso_b;
    logic [127:0] regs_b;
    logic         stb_b;
    logic [6:0]   idx_b;
    logic [7:0]   err_b;

    int           checks = 0;
    int           errors = 0;
    int           stb_a_n = 0;
    int           stb_mark;
    logic [31:0]  rx_a;
    logic [31:0]  rx_b;

    always #5 clk = ~clk;

    spi_regbank_sync dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (miso_a),
        .regs_out   (regs_a),
        .commit_stb (stb_a),
        .commit_idx (idx_a),
        .err_count  (err_a)
    );

    spi_regbank_sync #(.N_REGS(16), .REG_W(8)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_mosi   (spi_mosi),
        .spi_miso   (miso_b),
        .regs_out   (regs_b),
        .commit_stb (stb_b),
        .commit_idx (idx_b),
        .err_count  (err_b)
    );

    // Counts clk cycles with commit_stb high, so one pulse of one cycle adds exactly 1
    always @(posedge clk) begin
        if (stb_a === 1'b1) stb_a_n <= stb_a_n + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sclk_bit(input logic b);
        spi_mosi = b;
        #40;
        rx_a = {rx_a[30:0], miso_a};
        rx_b = {rx_b[30:0], miso_b};
        spi_clk = 1'b1;
        #40;
        spi_clk = 1'b0;
    endtask

    // Sends the low nbits of data, MSB first, and captures MISO of both instances
    task automatic spi_xfer(input logic [31:0] data, input int nbits);
        rx_a = '0;
        rx_b = '0;
        spi_cs = 1'b0;
        #80;
        for (int i = nbits - 1; i >= 0; i--) sclk_bit(data[i]);
        #40;
        spi_cs = 1'b1;
        spi_mosi = 1'b0;
        #200;
    endtask

    task automatic cs_glitch();
        spi_cs = 1'b0;
        #40;
        spi_cs = 1'b1;
        #60;
    endtask

    initial begin
        #30;
        rst_n = 1'b1;
        #100;
        check("reset_regs", regs_a, 0);
        check("reset_miso", miso_a, 0);
        check("reset_idx", idx_a, 0);
        check("reset_err", err_a, 0);
        check("reset_stb", stb_a, 0);

        stb_mark = stb_a_n;
        spi_xfer(32'h0705, 16);
        check("set_reg7", regs_a, 32'h5000_0000);
        check("set_stb", stb_a_n - stb_mark, 1);
        check("set_idx", idx_a, 7);

        spi_xfer(32'h0733, 16);
        check("toggle_reg7", regs_a, 32'h6000_0000);
        spi_xfer(32'h0740, 16);
        check("clear_reg7", regs_a, 32'h2000_0000);

        spi_xfer(32'h82FA, 16);
        check("direct_reg2", regs_a, 32'h2000_0A00);
        stb_mark = stb_a_n;
        spi_xfer(32'h0200, 16);
        check("readback_reg2", rx_a[15:0], 16'h00A0);
        check("readback_hold", regs_a, 32'h2000_0A00);
        check("readback_stb", stb_a_n - stb_mark, 1);

        stb_mark = stb_a_n;
        spi_xfer(32'h0385, 15);
        spi_xfer(32'h00F85, 17);
        check("badlen_regs", regs_a, 32'h2000_0A00);
        check("badlen_err", err_a, 2);
        check("badlen_stb", stb_a_n - stb_mark, 0);
        spi_xfer(32'h850C, 16);
        check("after_bad_commit", regs_a, 32'h20C0_0A00);
        check("after_bad_idx", idx_a, 5);

        for (int g = 0; g < 256; g++) cs_glitch();
        #100;
        check("err_saturate", err_a, 8'hFF);

        spi_xfer(32'h8009, 16);
        check("write_reg0", regs_a, 32'h20C0_0A09);
        stb_mark = stb_a_n;
        spi_xfer(32'h0B00, 16);
        check("soft_rst_regs", regs_a, 0);
        check("soft_rst_idx", idx_a, 11);
        check("soft_rst_stb", stb_a_n - stb_mark, 1);

        spi_xfer(32'h870F, 16);
        check("direct_reg7", regs_a, 32'hF000_0000);
        stb_mark = stb_a_n;
        spi_xfer(32'h7F0F, 16);
        check("range_regs", regs_a, 32'hF000_0000);
        check("range_stb", stb_a_n - stb_mark, 1);
        check("range_idx", idx_a, 127);
        check("range_readback", rx_a[15:0], 16'h0000);

        // Reset mid-frame: 6 + 10 bits would form a valid write of reg1 if not discarded
        spi_cs = 1'b0;
        #80;
        for (int i = 15; i >= 10; i--) sclk_bit(1'(32'h810F >> i));
        rst_n = 1'b0;
        #2;
        check("async_rst_regs", regs_a, 0);
        #18;
        rst_n = 1'b1;
        stb_mark = stb_a_n;
        for (int i = 9; i >= 0; i--) sclk_bit(1'(32'h810F >> i));
        #40;
        spi_cs = 1'b1;
        #200;
        check("midrst_regs", regs_a, 0);
        check("midrst_err", err_a, 0);
        check("midrst_stb", stb_a_n - stb_mark, 0);
        spi_xfer(32'h8103, 16);
        check("post_rst_commit", regs_a, 32'h0000_0030);
        check("post_rst_idx", idx_a, 1);

        spi_xfer(32'h0F00C3, 24);
        check("wide_reg15", regs_b[127:120], 8'hC3);
        check("wide_idx", idx_b, 15);
        spi_xfer(32'h0F0000, 24);
        check("wide_readback", rx_b[15:0], 16'hC300);
        check("wide_hold", regs_b[127:120], 8'hC3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
